// File: rtl/bus_generator_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_generator_arbiter_pkg
//   Shared definitions for the shared-bus generator/arbiter.
//   Contents:
//     ID_W        - width of the destination ID carried in each packet's MSBs
//     PKT_MAX     - widest packet the destination helper accepts
//     laneState_t - per-bus transaction FSM states (IDLE, POP, PUSH)
//     destOf()    - pulls the destination ID from a packet of width sz
// ---------------------------------------------------------------------------
package bus_generator_arbiter_pkg;

  localparam int ID_W    = 8;
  localparam int PKT_MAX = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } laneState_t;

  // The caller zero-extends its packet to PKT_MAX bits, so shifting the top
  // ID_W bits of the real packet down to bit 0 yields the destination.
  function automatic logic [ID_W-1:0] destOf(input logic [PKT_MAX-1:0] pkt,
                                             input int unsigned sz);
    return ID_W'(pkt >> (sz - ID_W));
  endfunction

endpackage

// File: rtl/bus_generator_arbiter_lane.sv
// ---------------------------------------------------------------------------
// bus_lane
//   One independent bus: round-robin arbiter, transaction FSM, packet
//   register and push decode.
//   Ports:
//     clk     - rising-edge clock
//     reset   - asynchronous active-low reset
//     pndng   - per-terminal FIFO non-empty flags
//     D_pop   - per-terminal FIFO head word (first-word fall-through)
//     pop     - registered one-cycle dequeue strobe per terminal
//     push    - registered one-cycle enqueue strobe per terminal
//     D_push  - packet presented to every terminal (held between pushes)
// ---------------------------------------------------------------------------
module bus_lane
  import bus_generator_arbiter_pkg::*;
#(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [drvrs-1:0]                  pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]     D_pop,
  output logic [drvrs-1:0]                  pop,
  output logic [drvrs-1:0]                  push,
  output logic [drvrs-1:0][pckg_sz-1:0]     D_push
);

  localparam int SEL_W = $clog2(drvrs);

  laneState_t         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [drvrs-1:0]   push_q, push_d;

  // State and output registers; reset clears every output asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      pkt_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      pkt_q   <= pkt_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
    end
  end

  // Next-state logic. Strobes are computed one state ahead so that pop is
  // high during POP and push is high during PUSH straight from flops. The
  // packet register doubles as the D_push driver: it loads on the edge that
  // starts PUSH and therefore holds until the next PUSH begins.
  always_comb begin
    logic            found;
    int              idx;
    logic [ID_W-1:0] dest;
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    pkt_d   = pkt_q;
    pop_d   = '0;
    push_d  = '0;
    found   = 1'b0;
    idx     = 0;
    dest    = '0;
    case (state_q)
      IDLE: begin
        // Search upward from the pointer with wrap; first pending wins.
        for (int i = 0; i < drvrs; i++) begin
          idx = int'(ptr_q) + i;
          if (idx >= drvrs) idx = idx - drvrs;
          if (!found && pndng[idx]) begin
            found = 1'b1;
            sel_d = SEL_W'(idx);
          end
        end
        if (found) begin
          pop_d[sel_d] = 1'b1;
          state_d      = POP;
        end
      end
      POP: begin
        pkt_d = D_pop[sel_q];
        dest  = destOf(PKT_MAX'(D_pop[sel_q]), pckg_sz);
        if (dest == broadcast) begin
          push_d        = '1;
          push_d[sel_q] = 1'b0;
        end else if (int'(dest) < drvrs) begin
          push_d[dest[SEL_W-1:0]] = 1'b1;
        end
        state_d = PUSH;
      end
      PUSH: begin
        ptr_d   = (int'(sel_q) == drvrs - 1) ? '0 : SEL_W'(sel_q + 1'b1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = pop_q;
  assign push = push_q;

  // Every terminal sees the same packet; only the push strobes select.
  always_comb begin
    for (int i = 0; i < drvrs; i++) D_push[i] = pkt_q;
  end

endmodule

// File: rtl/bus_generator_arbiter.sv
// ---------------------------------------------------------------------------
// bus_generator_arbiter
//   Shared-bus generator/arbiter: moves packets from granted terminal FIFOs
//   to the terminal named in the packet's top byte (or to all others on
//   broadcast). One bus_lane per parallel bus.
//   Ports:
//     clk     - rising-edge clock
//     reset   - asynchronous active-low reset
//     pndng   - [bits][drvrs] FIFO non-empty flags
//     D_pop   - [bits][drvrs] FIFO head words
//     pop     - [bits][drvrs] dequeue strobes
//     push    - [bits][drvrs] enqueue strobes
//     D_push  - [bits][drvrs] packets presented to terminals
// ---------------------------------------------------------------------------
module bus_generator_arbiter
  import bus_generator_arbiter_pkg::*;
#(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [bits-1:0][drvrs-1:0]                pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [bits-1:0][drvrs-1:0]                pop,
  output logic [bits-1:0][drvrs-1:0]                push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);

  // Buses share nothing but the clock and reset.
  for (genvar b = 0; b < bits; b++) begin : g_lane
    bus_lane #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng[b]),
      .D_pop  (D_pop[b]),
      .pop    (pop[b]),
      .push   (push[b]),
      .D_push (D_push[b])
    );
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_generator_arbiter
//   Directed bench for bus_generator_arbiter with bits=1, drvrs=4,
//   pckg_sz=32. Inputs change and outputs are sampled 1ns after each rising
//   edge.
// ---------------------------------------------------------------------------
module tb_bus_generator_arbiter;

  localparam int BITS  = 1;
  localparam int DRVRS = 4;
  localparam int PSZ   = 32;

  logic                                 clk = 1'b0;
  logic                                 reset;
  logic [BITS-1:0][DRVRS-1:0]           pndng;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]  D_pop;
  logic [BITS-1:0][DRVRS-1:0]           pop;
  logic [BITS-1:0][DRVRS-1:0]           push;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]  D_push;

  int checks = 0;
  int errors = 0;

  bus_generator_arbiter #(
    .bits      (BITS),
    .drvrs     (DRVRS),
    .pckg_sz   (PSZ),
    .broadcast (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Strobes plus the shared packet on terminal 0 (all terminals must match).
  task automatic checkBus(input string tag, input logic [3:0] expPop,
                          input logic [3:0] expPush, input logic [31:0] expData);
    checkOutput({tag, "_pop"},  32'(pop[0]),  32'(expPop));
    checkOutput({tag, "_push"}, 32'(push[0]), 32'(expPush));
    checkOutput({tag, "_data0"}, D_push[0][0], expData);
    checkOutput({tag, "_data3"}, D_push[0][3], expData);
  endtask

  task automatic applyStimulus(input logic [3:0] pend);
    pndng[0] = pend;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin phase expectations: source and destination per grant.
  logic [3:0]  rrPop  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0]  rrPush [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [31:0] rrData [5] = '{32'h01000000, 32'h02000011, 32'h03000022,
                              32'h00000033, 32'h01000000};

  initial begin
    // 1. Reset held with everything pending: nothing moves.
    reset    = 1'b0;
    pndng    = '0;
    D_pop[0][0] = 32'h01000000;
    D_pop[0][1] = 32'h05000001;
    D_pop[0][2] = 32'h05000002;
    D_pop[0][3] = 32'h05000003;
    applyStimulus(4'b1111);
    #2;
    checkBus("rst_early", 4'b0000, 4'b0000, 32'h0);
    tick(); tick(); tick();
    checkBus("rst_hold", 4'b0000, 4'b0000, 32'h0);
    reset = 1'b1;
    tick();
    checkBus("rst_first_pop", 4'b0001, 4'b0000, 32'h0);
    applyStimulus(4'b0000);
    tick();
    checkBus("rst_first_push", 4'b0000, 4'b0010, 32'h01000000);
    tick();
    checkBus("rst_first_idle", 4'b0000, 4'b0000, 32'h01000000);

    // 2. Unicast 1 -> 2.
    D_pop[0][1] = 32'h02ABCDEF;
    applyStimulus(4'b0010);
    tick();
    checkBus("uni_pop", 4'b0010, 4'b0000, 32'h01000000);
    applyStimulus(4'b0000);
    tick();
    checkBus("uni_push", 4'b0000, 4'b0100, 32'h02ABCDEF);
    tick();
    checkBus("uni_idle", 4'b0000, 4'b0000, 32'h02ABCDEF);

    // 3. Broadcast from terminal 3: everyone but the source.
    D_pop[0][3] = 32'hFF001122;
    applyStimulus(4'b1000);
    tick();
    checkBus("bc_pop", 4'b1000, 4'b0000, 32'h02ABCDEF);
    applyStimulus(4'b0000);
    tick();
    checkBus("bc_push", 4'b0000, 4'b0111, 32'hFF001122);
    tick();
    checkBus("bc_idle", 4'b0000, 4'b0000, 32'hFF001122);

    // 5. Invalid destination: popped, never pushed.
    D_pop[0][0] = 32'h07000000;
    applyStimulus(4'b0001);
    tick();
    checkBus("inv_pop", 4'b0001, 4'b0000, 32'hFF001122);
    applyStimulus(4'b0000);
    tick();
    checkBus("inv_nopush", 4'b0000, 4'b0000, 32'h07000000);
    tick();
    checkBus("inv_idle", 4'b0000, 4'b0000, 32'h07000000);

    // 6. Reset during POP clears outputs without waiting for a clock.
    applyStimulus(4'b0100);
    tick();
    checkBus("mid_pop", 4'b0100, 4'b0000, 32'h07000000);
    reset = 1'b0;
    #1;
    checkBus("mid_rst", 4'b0000, 4'b0000, 32'h0);
    D_pop[0][0] = 32'h01000000;
    D_pop[0][1] = 32'h02000011;
    D_pop[0][2] = 32'h03000022;
    D_pop[0][3] = 32'h00000033;
    applyStimulus(4'b1111);
    tick();
    checkBus("mid_hold", 4'b0000, 4'b0000, 32'h0);
    reset = 1'b1;

    // 4. Continuous pending after reset: grants 0,1,2,3,0 every 3 cycles.
    for (int k = 0; k < 5; k++) begin
      tick();
      checkBus($sformatf("rr%0d_pop", k), rrPop[k], 4'b0000,
               (k == 0) ? 32'h0 : rrData[k-1]);
      tick();
      checkBus($sformatf("rr%0d_push", k), 4'b0000, rrPush[k], rrData[k]);
      tick();
      checkBus($sformatf("rr%0d_idle", k), 4'b0000, 4'b0000, rrData[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_generator_arbiter.md
# bus_generator_arbiter

Shared-bus generator and arbiter connecting `drvrs` terminal FIFOs over one or more parallel buses. It pops a pending packet from a granted terminal and pushes it to the terminal addressed in the packet's most-significant byte, or to every other terminal on broadcast. It sits between the terminal FIFO models and the interface the verification environment drives.

## Interface
- `bits`: default 1. Number of independent parallel buses.
- `drvrs`: default 4. Terminals per bus (≥2, ≤255).
- `pckg_sz`: default 32. Packet width in bits (≥9).
- `broadcast`: default `8'hFF`. Destination ID meaning "all terminals".

Ports:
- `clk` (in, 1): single clock; all logic on rising edge.
- `reset` (in, 1): asynchronous, active-low reset.
- `pndng` (in, [bits][drvrs]): terminal FIFO non-empty.
- `D_pop` (in, [bits][drvrs] × pckg_sz): head word of each terminal FIFO, first-word fall-through.
- `pop` (out, [bits][drvrs]): one-cycle dequeue strobe to a terminal.
- `push` (out, [bits][drvrs]): one-cycle enqueue strobe to a terminal.
- `D_push` (out, [bits][drvrs] × pckg_sz): packet presented to terminals.

## Operation
- Each bus index b operates independently with identical logic.
- Packet format: destination ID = `D_pop[pckg_sz-1 -: 8]`; remaining bits are payload. The packet is forwarded unmodified.
- FSM per bus:
  - IDLE: if any `pndng` is high, grant the first pending terminal at or after round-robin pointer `ptr` (searching upward, wrapping). Register the grant as `sel` and go to POP. Otherwise stay in IDLE.
  - POP: assert `pop[sel]` for this cycle only. Capture `D_pop[sel]` into `pkt`. Go to PUSH.
  - PUSH: drive `D_push[*] = pkt` on all terminals. Then:
    - If destination is `broadcast`, assert `push[i]` for every i ≠ sel.
    - Else if destination < drvrs, assert `push[dest]` (self-addressed packets are delivered to the source).
    - Else, discard: no push.
    - Set `ptr = (sel+1) mod drvrs` and go to IDLE.
- `pndng` changes outside IDLE are ignored until the next IDLE.
- At most one pop per bus per transaction. Pop and push are never asserted in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `push` = 0, `pop` = 0, `D_push` = 0, `ptr` = 0, `sel` = 0, `pkt` = 0, FSM in IDLE.
- `pndng` sampled high at edge N in IDLE:
  - `pop` is high during cycle N+1.
  - `push` is high during cycle N+2.
  - Earliest next grant is sampled at edge N+3.
  - Throughput is one packet per 3 cycles per bus.
- `D_push` holds `pkt` from the PUSH cycle until the next PUSH.
- Simultaneous `pndng` on several terminals: round-robin from `ptr`. Starting from reset with all pending, grant order is 0,1,2,3,0…
- Reset asserted mid-transaction: outputs clear immediately (asynchronously). The in-flight packet is lost; it may already have been popped.
- `ptr` wraps from drvrs-1 to 0.

## Structure
- Shared package holds:
  - the ID width constant (8);
  - the FSM state enum (IDLE, POP, PUSH);
  - a helper function extracting the destination from a packet.
- Top module `bus_generator_arbiter` uses a generate loop over `bits`, instantiating one sub-module `bus_lane` per bus. `bus_lane` contains the FSM, round-robin arbiter, packet register and push decode.

## Test plan
All scenarios use drvrs=4, pckg_sz=32, bits=1.
1. Reset: hold `reset`=0 with `pndng`=4'b1111. `push`, `pop` and `D_push` stay 0. After release, the first pop is to terminal 0.
2. Unicast: terminal 1 pending with `32'h02ABCDEF`. `pop[1]` pulses one cycle, then `push[2]` pulses the next cycle with `D_push`=`32'h02ABCDEF`. No other strobes.
3. Broadcast: terminal 3 sends `32'hFF001122`. Pushes go to terminals 0, 1 and 2 simultaneously, none to 3.
4. Round-robin: all four terminals continuously pending. Pops occur in order 0,1,2,3,0, spaced 3 cycles apart.
5. Invalid destination: terminal 0 sends `32'h07000000`. Pop occurs, no push, FSM returns to IDLE.
6. Reset mid-transaction: assert reset during the POP cycle. Outputs clear immediately. After release, arbitration restarts from terminal 0.
